// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch path.
// Entry layout, reset fetch address and counter-width helper.
package fetch_pkg;

    localparam int          FETCH_AW           = 32;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]         rdata;
        logic [FETCH_AW-1:0] addr;
        logic                err;
    } fetch_entry_t;

    // Bits needed to index 'value' items; never less than one.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >>> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Generic synchronous FIFO with flush; 1-cycle write-to-read latency, no fall-through.
// Push is dropped only when full without a simultaneous pop; flush has priority over push/pop.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH     = 4,
    parameter type T         = logic [7:0],
    parameter T    RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  T                          push_data_i,
    input  logic                      pop_i,
    output T                          head_o,
    output logic [clog2(DEPTH+1)-1:0] count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    // A pop frees the slot the same-cycle push needs, so full+pop+push is legal.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Pipelined instruction prefetcher: gnt at N, rvalid at N+1 earliest, instr_valid_o at N+2.
// Requests stall when outstanding + buffered words would exceed FIFO space; decode stalls via instr_ready_i.
module prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR      = ADDR_WIDTH'(RESET_ADDR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_err_o,
    output logic                  busy_o,
    output logic                  imem_req_o,
    input  logic                  imem_gnt_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_err_i
);

    localparam int OW = clog2(MAX_OUTSTANDING + 1);
    localparam int QW = clog2(MAX_OUTSTANDING);
    localparam int CW = clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  err;
    } entry_t;

    localparam entry_t ENTRY_RST = '{rdata: '0, addr: RESET_ADDR, err: 1'b0};

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         discard_cnt;
    logic                  fab_vld;
    logic                  fab_bit;
    logic [ADDR_WIDTH-1:0] aq [MAX_OUTSTANDING];
    logic [QW-1:0]         aq_wr;
    logic [QW-1:0]         aq_rd;

    logic                  grant;
    logic                  resp;
    logic                  accept;
    logic                  slots_ok;
    logic [ADDR_WIDTH-1:0] resp_addr;
    entry_t                push_entry;
    entry_t                head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_bits;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_bits = branch_addr_i[0];

    // Slots are reserved at grant so every accepted response has FIFO space.
    assign slots_ok   = (int'(outstanding) < MAX_OUTSTANDING) &&
                        (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH);
    assign imem_req_o = rst_n & req_i & ~branch_i & ~fifo_full & slots_ok;
    assign imem_addr_o = fetch_addr;
    assign grant      = imem_req_o & imem_gnt_i;

    // A response with nothing in flight is spurious and ignored entirely.
    assign resp       = imem_rvalid_i & (outstanding != '0);
    assign accept     = resp & (discard_cnt == '0) & ~branch_i;
    assign resp_addr  = aq[aq_rd];

    always_comb begin
        push_entry       = '0;
        push_entry.rdata = imem_rdata_i;
        push_entry.err   = imem_err_i;
        push_entry.addr  = fab_vld ? {resp_addr[ADDR_WIDTH-1:2], fab_bit, 1'b0} : resp_addr;
    end

    prefetch_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .T         (entry_t),
        .RESET_VAL (ENTRY_RST)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (branch_i),
        .push_i      (accept),
        .push_data_i (push_entry),
        .pop_i       (instr_valid_o & instr_ready_i & ~branch_i),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign instr_valid_o = ~fifo_empty;
    assign instr_rdata_o = head.rdata;
    assign instr_addr_o  = head.addr;
    assign instr_err_o   = head.err;
    assign busy_o        = (outstanding != '0) | (discard_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr  <= RESET_ADDR;
            outstanding <= '0;
            discard_cnt <= '0;
            fab_vld     <= 1'b0;
            fab_bit     <= 1'b0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                aq[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + OW'(grant) - OW'(resp);
            if (grant) begin
                aq[aq_wr] <= fetch_addr;
                aq_wr     <= q_next(aq_wr);
            end
            if (resp) begin
                aq_rd <= q_next(aq_rd);
            end
            // Stale responses still drain the address queue, keeping it aligned with the bus.
            if (branch_i) begin
                fetch_addr  <= {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
                discard_cnt <= outstanding - OW'(resp);
                fab_vld     <= 1'b1;
                fab_bit     <= branch_addr_i[1];
            end else begin
                if (grant) begin
                    fetch_addr <= fetch_addr + ADDR_WIDTH'(4);
                end
                if (resp && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - 1'b1;
                end
                if (accept) begin
                    fab_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Parametrised successor to the single-request fetch stage.
- Issues pipelined instruction-memory requests (req/gnt address phase, rvalid data phase) with up to MAX_OUTSTANDING in flight.
- Buffers returned words in a FIFO_DEPTH-entry prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles branch redirects mid-flight by flushing the FIFO and discarding stale responses.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction word width; fixed at 32 in this generation.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; must be <= FIFO_DEPTH.
- RESET_ADDR, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch enable from controller.
- branch_i  in  1  redirect strobe, one cycle.
- branch_addr_i  in  ADDR_WIDTH  redirect target (halfword aligned).
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  decode accepts head.
- instr_rdata_o  out  DATA_WIDTH  head instruction word.
- instr_addr_o  out  ADDR_WIDTH  head address.
- instr_err_o  out  1  head fetched with bus error.
- busy_o  out  1  outstanding != 0 or discard_cnt != 0.
- imem_req_o  out  1  address-phase request.
- imem_gnt_i  in  1  address phase accepted.
- imem_addr_o  out  ADDR_WIDTH  request address, bits [1:0] always 0.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  DATA_WIDTH  response data.
- imem_err_i  in  1  response error, qualified by rvalid.

Behaviour:
- Reset values:
  - fetch_addr = RESET_ADDR; FIFO empty; outstanding = 0; discard_cnt = 0.
  - instr_valid_o = 0, instr_rdata_o = 0, instr_addr_o = RESET_ADDR, instr_err_o = 0.
  - imem_req_o = 0, busy_o = 0.
- Request condition: imem_req_o = req_i & !branch_i & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < FIFO_DEPTH). Slots are reserved at grant, so the FIFO can never overflow.
- imem_addr_o = fetch_addr. On req & gnt: fetch_addr += 4 (wraps modulo 2^ADDR_WIDTH), outstanding += 1.
- Once imem_req_o is asserted, address and req are held until gnt. Exceptions:
  - branch_i drops req in that cycle.
  - req_i deasserting may drop req.
- Response: rvalid with discard_cnt == 0 writes {rdata, err, resp_addr} into the FIFO and decrements outstanding.
  - resp_addr comes from an internal address queue (depth MAX_OUTSTANDING) loaded at grant.
  - rvalid with an unexpected empty queue is ignored.
- Latency: gnt at cycle N, earliest rvalid at N+1, instr_valid_o at N+2 (no fall-through). Back-to-back gnt/rvalid sustains 1 word/cycle when MAX_OUTSTANDING >= 2.
- Output: head is presented while FIFO non-empty; pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Branch (branch_i = 1), effects in the same cycle:
  - FIFO cleared; any pop or push that cycle is dropped.
  - fetch_addr <= {branch_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - discard_cnt <= outstanding - (imem_rvalid_i ? 1 : 0).
  - outstanding is retained for slot accounting; no request is issued that cycle.
  - first_after_branch flag set, holding branch_addr_i[1].
- Discard: rvalid with discard_cnt > 0 decrements both discard_cnt and outstanding; no push. New requests may issue during discard, but their responses are accepted only after discard_cnt reaches 0 (responses are in order).
- First word after branch: instr_addr_o = {word_addr[ADDR_WIDTH-1:2], flag, 1'b0}. The flag clears on push of that word. All other entries have instr_addr_o[1:0] = 0.
- Branch during discard: discard_cnt is recomputed from the current outstanding as above.
- Branch and grant in the same cycle cannot occur, because req is 0 during a branch cycle.
- imem_err_i: the word is pushed with err = 1. Fetching continues; decode handles the trap.
- req_i = 0: no new requests. In-flight responses still complete into the FIFO.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {logic [31:0] rdata; logic [ADDR_WIDTH-1:0] addr; logic err}.
  - RESET_ADDR default constant.
  - clog2 helper for counter widths.
- One sub-module: prefetch_fifo (parametrised DEPTH, generic payload, synchronous flush_i, push/pop/count/full/empty).
- Address queue and counters live in the top module.

Test Plan:
- Streaming: req_i = 1, memory gnt always, rvalid next cycle with rdata = addr, ready always 1 → instr_addr_o sequence 0x0, 0x4, 0x8, …; one word per cycle after a 2-cycle initial latency.
- Backpressure: instr_ready_i = 0 for 10 cycles → exactly FIFO_DEPTH = 4 requests issued, imem_req_o = 0 after that, no word lost. On release, words 0x0 through 0xC are delivered in order.
- Branch with 2 in flight: branch_i with branch_addr_i = 0x102 → FIFO empties; 2 stale responses dropped. Next fetch is at 0x100, and the first output has instr_addr_o = 0x102, followed by 0x104.
- Branch on an rvalid cycle: outstanding = 2, rvalid = 1 when branch_i = 1 → discard_cnt = 1; exactly one further response is discarded.
- Error response: imem_err_i = 1 on the word at 0x8 → instr_err_o = 1 only for that entry; 0xC is fetched normally.
- Async reset mid-stream: rst_n low with 2 outstanding → all outputs return to reset values immediately. After release, fetch restarts at RESET_ADDR.
